// File: rtl/counter_start_scheduler.sv
// counter_start_scheduler: queues start requests and paces one-cycle start pulses to up_down_counter.
// Define DONE_COUNT_EN to add out_done_count, a 16-bit wrapping count of completions.
module counter_start_scheduler #(
    parameter int unsigned PEND_W      = 3,
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter int unsigned RUN_TIMEOUT = 64
) (
    input  logic              in_clock,
    input  logic              in_reset,
    input  logic              in_request,
    input  logic              in_flush,
    input  logic              in_counter_ready,
    output logic              out_start,
    output logic [PEND_W-1:0] out_pending,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_overflow,
    output logic              out_timeout
`ifdef DONE_COUNT_EN
    ,output logic [15:0]      out_done_count
`endif
);
    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, RUN} state_t;
    localparam logic [15:0]       ACK_LIM  = 16'(ACK_TIMEOUT);
    localparam logic [15:0]       RUN_LIM  = 16'(RUN_TIMEOUT);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    state_t            state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic              deq;
`ifdef DONE_COUNT_EN
    logic [15:0]       done_count_q, done_count_d;
`endif
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        pending_d  = pending_q;
        deq        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0 && in_counter_ready) begin
                    state_d = START;
                    start_d = 1'b1;
                    deq     = 1'b1;
                end
            end
            START: begin
                state_d = WAIT_ACK;
                timer_d = '0;
            end
            WAIT_ACK: begin
                if (!in_counter_ready) begin
                    state_d = RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                    if (timer_d == ACK_LIM) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (in_counter_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                    if (timer_d == RUN_LIM) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        // Flush wins over any same-cycle request or sticky-flag set
        if (in_flush) begin
            pending_d  = '0;
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
        end else if (in_request && !deq) begin
            if (pending_q == PEND_MAX)
                overflow_d = 1'b1;
            else
                pending_d = pending_q + 1'b1;
        end else if (!in_request && deq) begin
            pending_d = pending_q - 1'b1;
        end
`ifdef DONE_COUNT_EN
        done_count_d = done_d ? done_count_q + 16'd1 : done_count_q;
`endif
    end
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            pending_q    <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef DONE_COUNT_EN
            done_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            start_q      <= start_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
`ifdef DONE_COUNT_EN
            done_count_q <= done_count_d;
`endif
        end
    end
    assign out_start    = start_q;
    assign out_pending  = pending_q;
    assign out_busy     = busy_q;
    assign out_done     = done_q;
    assign out_overflow = overflow_q;
    assign out_timeout  = timeout_q;
`ifdef DONE_COUNT_EN
    assign out_done_count = done_count_q;
`endif
endmodule

// File: tb/tb_counter_start_scheduler.sv
// tb_counter_start_scheduler: directed bench with a simple busy/idle model of the downstream counter.
module tb_counter_start_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       flush = 1'b0;
    logic       ready;
    logic       out_start, out_busy, out_done, out_overflow, out_timeout;
    logic [2:0] out_pending;
`ifdef DONE_COUNT_EN
    logic [15:0] out_done_count;
`endif
    int  total = 0;
    int  bad = 0;
    int  n_start = 0;
    int  n_done = 0;
    bit  seq_err = 1'b0;
    bit  hold = 1'b0;
    bit  never_ack = 1'b0;
    int  busy_len = 20;
    logic m_busy;
    int  m_cnt;
    int  base_s, base_d, n;

    counter_start_scheduler dut (
        .in_clock(clk), .in_reset(rst), .in_request(req), .in_flush(flush),
        .in_counter_ready(ready), .out_start(out_start), .out_pending(out_pending),
        .out_busy(out_busy), .out_done(out_done), .out_overflow(out_overflow),
        .out_timeout(out_timeout)
`ifdef DONE_COUNT_EN
        , .out_done_count(out_done_count)
`endif
    );

    always #5 clk = ~clk;
    assign ready = !m_busy && !hold;

    // Counter model: goes busy the edge after it sees a start, stays busy busy_len cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (out_start && !never_ack) begin
            m_busy <= 1'b1;
            m_cnt  <= busy_len;
        end else if (m_busy) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (out_start) begin
            if (n_start != n_done) seq_err <= 1'b1;
            n_start <= n_start + 1;
        end
        if (out_done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int want, input int max);
        int k = 0;
        while ((n_done < want || out_busy) && k < max) begin
            step();
            k++;
        end
        chk("wait_bound", 32'(k < max), 1);
    endtask

    initial begin
        #1;
        chk("reset_outs", {out_start, out_pending, out_busy, out_done, out_overflow, out_timeout}, 0);
        step();
        step();
        rst = 1'b0;
        // Single request, 20-cycle busy counter
        req = 1'b1;
        step();
        req = 1'b0;
        chk("t1_pend1", out_pending, 1);
        chk("t1_nostart", out_start, 0);
        step();
        chk("t1_start", out_start, 1);
        chk("t1_busy", out_busy, 1);
        chk("t1_pend0", out_pending, 0);
        n = 0;
        while (!out_done && n < 40) begin
            step();
            n++;
        end
        chk("t1_done_lat", n, 22);
        chk("t1_done_idle", out_busy, 0);
        step();
        chk("t1_done_pulse", out_done, 0);
        chk("t1_starts", n_start, 1);
        // Five back-to-back requests
        busy_len = 3;
        base_s = n_start;
        base_d = n_done;
        req = 1'b1;
        repeat (5) step();
        req = 1'b0;
        chk("t2_peak", out_pending, 4);
        wait_done(base_d + 5, 200);
        chk("t2_starts", n_start - base_s, 5);
        chk("t2_pend0", out_pending, 0);
        // Nine requests against a held-busy counter
        hold = 1'b1;
        busy_len = 2;
        base_s = n_start;
        base_d = n_done;
        req = 1'b1;
        repeat (9) step();
        req = 1'b0;
        chk("t3_pend7", out_pending, 7);
        chk("t3_ovf", out_overflow, 1);
        chk("t3_held", n_start - base_s, 0);
        hold = 1'b0;
        wait_done(base_d + 7, 300);
        chk("t3_starts", n_start - base_s, 7);
        chk("t3_pend0", out_pending, 0);
        chk("t3_ovf_sticky", out_overflow, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_flush_ovf", out_overflow, 0);
        hold = 1'b1;
        req = 1'b1;
        repeat (2) step();
        chk("t3_pend2", out_pending, 2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        req = 1'b0;
        chk("t3_flush_req", {out_pending, out_overflow}, 0);
        hold = 1'b0;
        step();
        chk("t3_no_start", out_start, 0);
        chk("t3_seq", seq_err, 0);
        // Ack timeout, with a second request queued behind it
        never_ack = 1'b1;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("t4_start", out_start, 1);
        req = 1'b1;
        step();
        req = 1'b0;
        chk("t4_pend1", out_pending, 1);
        repeat (3) step();
        chk("t4_not_yet", {out_timeout, out_busy}, 2'b01);
        step();
        chk("t4_timeout", {out_timeout, out_busy}, 2'b10);
        never_ack = 1'b0;
        busy_len = 3;
        base_d = n_done;
        step();
        chk("t4_restart", {out_start, out_pending}, 4'b1000);
        wait_done(base_d + 1, 50);
        chk("t4_sticky", out_timeout, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_to", out_timeout, 0);
        // Run timeout
        busy_len = 100;
        base_d = n_done;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("t5_start", out_start, 1);
        repeat (65) step();
        chk("t5_not_yet", {out_timeout, out_busy}, 2'b01);
        step();
        chk("t5_timeout", {out_timeout, out_busy, out_done}, 3'b100);
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("t5_no_done", n_done - base_d, 0);
`ifdef DONE_COUNT_EN
        chk("t5_done_count", out_done_count, 32'(16'(n_done)));
`endif
        // Reset during RUN with three queued requests
        flush = 1'b1;
        step();
        flush = 1'b0;
        busy_len = 30;
        req = 1'b1;
        step();
        req = 1'b0;
        repeat (3) step();
        req = 1'b1;
        repeat (3) step();
        req = 1'b0;
        chk("t6_pend3", {out_pending, out_busy}, 4'b0111);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_outs", {out_start, out_pending, out_busy, out_done, out_overflow, out_timeout}, 0);
        base_s = n_start;
        repeat (2) step();
        chk("t6_rst_hold", {out_start, out_done, out_busy}, 0);
        rst = 1'b0;
        repeat (5) step();
        chk("t6_no_start", n_start - base_s, 0);
        chk("t6_pend0", out_pending, 0);
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("t6_new_start", out_start, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
